// File: rtl/bbox_sample_iter_if.sv
// Bus between the bounding-box stage (R13) and the sample stages (R14).
// Carries the incoming triangle/box/step request and the outgoing sample stream.
// master = the sample iterator, slave = its environment (upstream + downstream).
interface bbox_sample_iter_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    // Upstream side (R13): triangle, colour, box [0]=LL,[1]=UR; [.][0]=x,[.][1]=y
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnL;

    // Downstream side (R14): latched triangle/colour and current sample (x,y)
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/bbox_sample_iter.sv
// Walks a triangle's pixel-aligned bounding box in raster order, one sample per cycle.
// Latency 1: first sample (box LL corner) is valid the cycle after the triangle is accepted.
// Upstream is held off (halt_RnnnnL low) until the last sample; no downstream backpressure.
module bbox_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic               clk,
    input  logic               rst,
    bbox_sample_iter_if.master bus
);

    typedef enum logic [1:0] {
        WAIT_STATE = 2'b00,
        TEST_STATE = 2'b01
    } state_t;

    localparam logic [SIGFIG-1:0] ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

    state_t                                 state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [SIGFIG-1:0]                      samp_x_q, samp_x_d;
    logic [SIGFIG-1:0]                      samp_y_q, samp_y_d;
    logic [SIGFIG-1:0]                      ll_x_q, ll_x_d;
    logic [SIGFIG-1:0]                      ll_y_q, ll_y_d;
    logic [SIGFIG-1:0]                      ur_x_q, ur_x_d;
    logic [SIGFIG-1:0]                      ur_y_q, ur_y_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic                                   valid_q, valid_d;

    // One extra bit on the step adders so a box ending near max positive never wraps.
    logic signed [SIGFIG:0] x_inc, y_inc, ur_x_ext, ur_y_ext;
    logic                   x_past, y_past, at_last;
    logic                   halt, accept, box_ok;
    logic [SIGFIG-1:0]      new_step;

    // Decode the one-hot subsample selector into a fixed-point step; unknown codes mean 1 px.
    always_comb begin
        new_step = ONE << RADIX;
        case (bus.subSample_RnnnnU)
            4'b1000: new_step = ONE << RADIX;
            4'b0100: new_step = ONE << (RADIX - 1);
            4'b0010: new_step = ONE << (RADIX - 2);
            4'b0001: new_step = ONE << (RADIX - 3);
            default: new_step = ONE << RADIX;
        endcase
    end

    // Position of the next step and whether the walk has reached its final sample.
    always_comb begin
        x_inc    = $signed({samp_x_q[SIGFIG-1], samp_x_q}) + $signed({1'b0, step_q});
        y_inc    = $signed({samp_y_q[SIGFIG-1], samp_y_q}) + $signed({1'b0, step_q});
        ur_x_ext = $signed({ur_x_q[SIGFIG-1], ur_x_q});
        ur_y_ext = $signed({ur_y_q[SIGFIG-1], ur_y_q});
        x_past   = x_inc > ur_x_ext;
        y_past   = y_inc > ur_y_ext;
        at_last  = x_past && y_past;
    end

    // Upstream handshake: ready when idle or on the last sample, so walks chain without bubbles.
    always_comb begin
        halt   = (state_q == WAIT_STATE) || ((state_q == TEST_STATE) && at_last);
        accept = bus.validTri_R13H && halt;
        box_ok = ($signed(bus.box_R13S[0][0]) <= $signed(bus.box_R13S[1][0])) &&
                 ($signed(bus.box_R13S[0][1]) <= $signed(bus.box_R13S[1][1]));
    end

    // Next-state: load a new triangle, advance the raster walk, or drop back to idle.
    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        samp_x_d = samp_x_q;
        samp_y_d = samp_y_q;
        ll_x_d   = ll_x_q;
        ll_y_d   = ll_y_q;
        ur_x_d   = ur_x_q;
        ur_y_d   = ur_y_q;
        step_d   = step_q;
        valid_d  = valid_q;

        case (state_q)
            WAIT_STATE: begin
                // An inverted box is swallowed: nothing latched, no samples.
                if (accept && box_ok) begin
                    state_d  = TEST_STATE;
                    valid_d  = 1'b1;
                    tri_d    = bus.tri_R13S;
                    color_d  = bus.color_R13U;
                    ll_x_d   = bus.box_R13S[0][0];
                    ll_y_d   = bus.box_R13S[0][1];
                    ur_x_d   = bus.box_R13S[1][0];
                    ur_y_d   = bus.box_R13S[1][1];
                    samp_x_d = bus.box_R13S[0][0];
                    samp_y_d = bus.box_R13S[0][1];
                    step_d   = new_step;
                end
            end
            TEST_STATE: begin
                if (at_last) begin
                    if (accept && box_ok) begin
                        valid_d  = 1'b1;
                        tri_d    = bus.tri_R13S;
                        color_d  = bus.color_R13U;
                        ll_x_d   = bus.box_R13S[0][0];
                        ll_y_d   = bus.box_R13S[0][1];
                        ur_x_d   = bus.box_R13S[1][0];
                        ur_y_d   = bus.box_R13S[1][1];
                        samp_x_d = bus.box_R13S[0][0];
                        samp_y_d = bus.box_R13S[0][1];
                        step_d   = new_step;
                    end else begin
                        // Walk finished: outputs keep their last values, only valid drops.
                        state_d = WAIT_STATE;
                        valid_d = 1'b0;
                    end
                end else if (!x_past) begin
                    samp_x_d = x_inc[SIGFIG-1:0];
                end else begin
                    samp_x_d = ll_x_q;
                    samp_y_d = y_inc[SIGFIG-1:0];
                end
            end
            default: begin
                state_d = WAIT_STATE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_STATE;
            tri_q    <= '0;
            color_q  <= '0;
            samp_x_q <= '0;
            samp_y_q <= '0;
            ll_x_q   <= '0;
            ll_y_q   <= '0;
            ur_x_q   <= '0;
            ur_y_q   <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            samp_x_q <= samp_x_d;
            samp_y_q <= samp_y_d;
            ll_x_q   <= ll_x_d;
            ll_y_q   <= ll_y_d;
            ur_x_q   <= ur_x_d;
            ur_y_q   <= ur_y_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.halt_RnnnnL    = halt;
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S[0] = samp_x_q;
    assign bus.sample_R14S[1] = samp_y_q;
    assign bus.validSamp_R14H = valid_q;

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Bench for bbox_sample_iter: directed scenarios plus randomized boxes checked
// against a raster-loop reference model; inputs change and outputs are read on
// the falling clock edge.
module tb_bbox_sample_iter;

    typedef logic [2:0][2:0][23:0] tri_t;
    typedef logic [2:0][23:0]      col_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_x[$];
    int   exp_y[$];

    bbox_sample_iter_if #(.SIGFIG(24), .VERTS(3), .AXIS(3), .COLORS(3)) bus ();

    bbox_sample_iter #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic tri_t rand_tri();
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                t[v][a] = 24'($urandom);
        return t;
    endfunction

    function automatic col_t rand_col();
        col_t c;
        for (int k = 0; k < 3; k++) c[k] = 24'($urandom);
        return c;
    endfunction

    // Sample spacing in fixed point (10 fraction bits) for a subsample code.
    function automatic int step_of(input logic [3:0] s);
        case (s)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Reference: every grid point from LL up to UR, x fastest.
    task automatic model_walk(input int llx, input int lly, input int urx, input int ury, input int step);
        exp_x.delete();
        exp_y.delete();
        for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    task automatic present(input tri_t t, input col_t c, input int llx, input int lly,
                           input int urx, input int ury, input logic [3:0] sub);
        bus.tri_R13S         = t;
        bus.color_R13U       = c;
        bus.box_R13S[0][0]   = 24'(llx);
        bus.box_R13S[0][1]   = 24'(lly);
        bus.box_R13S[1][0]   = 24'(urx);
        bus.box_R13S[1][1]   = 24'(ury);
        bus.subSample_RnnnnU = sub;
        bus.validTri_R13H    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.validTri_R13H = 1'b0;
        present(rand_tri(), rand_col(), 0, 0, 0, 0, 4'b1000);
        bus.validTri_R13H = 1'b0;
        #12;
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.validSamp_R14H); end
        checks++; if (bus.halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL reset_halt got %b want 1", bus.halt_RnnnnL); end
        checks++; if (bus.sample_R14S !== 48'd0) begin errors++; $display("FAIL reset_sample got %h want 0", bus.sample_R14S); end
        checks++; if (bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin errors++; $display("FAIL reset_tri_color got %h/%h want 0", bus.tri_R14S, bus.color_R14U); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_raster();
        int   ex_x[6];
        int   ex_y[6];
        int   halt_low = 0;
        tri_t t = rand_tri();
        col_t c = rand_col();
        ex_x = '{0, 1024, 2048, 0, 1024, 2048};
        ex_y = '{0, 0, 0, 1024, 1024, 1024};
        @(negedge clk);
        present(t, c, 0, 0, 2048, 1024, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            if (bus.halt_RnnnnL !== 1'b1) halt_low++;
            checks++;
            if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'(ex_x[i]) || bus.sample_R14S[1] !== 24'(ex_y[i])) begin
                errors++;
                $display("FAIL raster_sample%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, bus.validSamp_R14H,
                         $signed(bus.sample_R14S[0]), $signed(bus.sample_R14S[1]), ex_x[i], ex_y[i]);
            end
            checks++; if (bus.tri_R14S !== t || bus.color_R14U !== c) begin errors++; $display("FAIL raster_tri%0d got %h want %h", i, bus.tri_R14S, t); end
        end
        @(negedge clk);
        if (bus.halt_RnnnnL !== 1'b1) halt_low++;
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL raster_end_valid got %b want 0", bus.validSamp_R14H); end
        checks++; if (bus.sample_R14S[0] !== 24'd2048 || bus.sample_R14S[1] !== 24'd1024) begin errors++; $display("FAIL raster_hold got (%0d,%0d) want (2048,1024)", bus.sample_R14S[0], bus.sample_R14S[1]); end
        checks++; if (halt_low !== 5) begin errors++; $display("FAIL raster_halt_low_cycles got %0d want 5", halt_low); end
    endtask

    task automatic test_single();
        int halt_low = 0;
        @(negedge clk);
        present(rand_tri(), rand_col(), 512, 512, 512, 512, 4'b1000);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        if (bus.halt_RnnnnL !== 1'b1) halt_low++;
        checks++; if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'd512 || bus.sample_R14S[1] !== 24'd512) begin errors++; $display("FAIL single_sample got v=%b (%0d,%0d) want v=1 (512,512)", bus.validSamp_R14H, bus.sample_R14S[0], bus.sample_R14S[1]); end
        @(negedge clk);
        if (bus.halt_RnnnnL !== 1'b1) halt_low++;
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", bus.validSamp_R14H); end
        checks++; if (halt_low !== 0) begin errors++; $display("FAIL single_halt_low got %0d want 0", halt_low); end
    endtask

    task automatic test_back_to_back();
        tri_t tri_a = rand_tri();
        tri_t tri_b = rand_tri();
        col_t c     = rand_col();
        tri_t et[4];
        int   ex[4];
        int   ey[4];
        et = '{tri_a, tri_a, tri_b, tri_b};
        ex = '{0, 1024, 4096, 5120};
        ey = '{0, 0, 2048, 2048};
        @(negedge clk);
        present(tri_a, c, 0, 0, 1024, 0, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) present(tri_b, c, 4096, 2048, 5120, 2048, 4'b1000);
            if (i == 2) bus.validTri_R13H = 1'b0;
            checks++; if (bus.validSamp_R14H !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b want 1", i, bus.validSamp_R14H); end
            checks++; if (bus.tri_R14S !== et[i]) begin errors++; $display("FAIL b2b_tri%0d got %h want %h", i, bus.tri_R14S, et[i]); end
            checks++; if (bus.sample_R14S[0] !== 24'(ex[i]) || bus.sample_R14S[1] !== 24'(ey[i])) begin errors++; $display("FAIL b2b_sample%0d got (%0d,%0d) want (%0d,%0d)", i, bus.sample_R14S[0], bus.sample_R14S[1], ex[i], ey[i]); end
        end
        @(negedge clk);
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", bus.validSamp_R14H); end
    endtask

    task automatic test_fine_step();
        @(negedge clk);
        present(rand_tri(), rand_col(), 0, 0, 1024, 0, 4'b0001);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            checks++;
            if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'(i * 128) || bus.sample_R14S[1] !== 24'd0) begin
                errors++;
                $display("FAIL fine_sample%0d got v=%b (%0d,%0d) want v=1 (%0d,0)", i, bus.validSamp_R14H, bus.sample_R14S[0], bus.sample_R14S[1], i * 128);
            end
        end
        @(negedge clk);
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL fine_end_valid got %b want 0", bus.validSamp_R14H); end
    endtask

    task automatic test_reset_mid_walk();
        tri_t t = rand_tri();
        @(negedge clk);
        present(rand_tri(), rand_col(), 0, 0, 2048, 2048, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
        end
        checks++; if (bus.sample_R14S[0] !== 24'd0 || bus.sample_R14S[1] !== 24'd1024) begin errors++; $display("FAIL midrst_4th got (%0d,%0d) want (0,1024)", bus.sample_R14S[0], bus.sample_R14S[1]); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.validSamp_R14H); end
        checks++; if (bus.sample_R14S !== 48'd0 || bus.tri_R14S !== '0) begin errors++; $display("FAIL midrst_clear got %h/%h want 0", bus.sample_R14S, bus.tri_R14S); end
        checks++; if (bus.halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL midrst_halt got %b want 1", bus.halt_RnnnnL); end
        @(negedge clk);
        rst = 1'b0;
        present(t, rand_col(), -3072, 5120, -3072, 5120, 4'b0010);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        checks++;
        if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'(-3072) || bus.sample_R14S[1] !== 24'd5120 || bus.tri_R14S !== t) begin
            errors++;
            $display("FAIL midrst_restart got v=%b (%0d,%0d) want v=1 (-3072,5120)", bus.validSamp_R14H, $signed(bus.sample_R14S[0]), bus.sample_R14S[1]);
        end
        @(negedge clk);
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL midrst_end got %b want 0", bus.validSamp_R14H); end
    endtask

    task automatic test_ignore_and_bad_box();
        tri_t tc = rand_tri();
        @(negedge clk);
        present(tc, rand_col(), 0, 0, 2048, 0, 4'b1000);
        @(negedge clk);
        checks++; if (bus.halt_RnnnnL !== 1'b0) begin errors++; $display("FAIL ign_halt got %b want 0", bus.halt_RnnnnL); end
        present(rand_tri(), rand_col(), 9000, 9000, 12000, 12000, 4'b0001);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        checks++; if (bus.tri_R14S !== tc || bus.sample_R14S[0] !== 24'd1024) begin errors++; $display("FAIL ign_tri got %h x=%0d want %h x=1024", bus.tri_R14S, bus.sample_R14S[0], tc); end
        @(negedge clk);
        checks++; if (bus.tri_R14S !== tc || bus.sample_R14S[0] !== 24'd2048) begin errors++; $display("FAIL ign_last got %h x=%0d want %h x=2048", bus.tri_R14S, bus.sample_R14S[0], tc); end
        @(negedge clk);
        present(rand_tri(), rand_col(), 2048, 0, 0, 0, 4'b1000);
        @(negedge clk);
        present(rand_tri(), rand_col(), 0, 1024, 0, -1024, 4'b1000);
        checks++; if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL badx got v=%b halt=%b want v=0 halt=1", bus.validSamp_R14H, bus.halt_RnnnnL); end
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        checks++; if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL bady got v=%b halt=%b want v=0 halt=1", bus.validSamp_R14H, bus.halt_RnnnnL); end
        checks++; if (bus.tri_R14S !== tc) begin errors++; $display("FAIL bad_tri_kept got %h want %h", bus.tri_R14S, tc); end
    endtask

    task automatic test_max_pos();
        int   maxp = 8388607;
        tri_t t = rand_tri();
        model_walk(maxp - 2048, maxp - 1024, maxp, maxp, 1024);
        @(negedge clk);
        present(t, rand_col(), maxp - 2048, maxp - 1024, maxp, maxp, 4'b1000);
        for (int i = 0; i < exp_x.size(); i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            checks++;
            if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'(exp_x[i]) || bus.sample_R14S[1] !== 24'(exp_y[i])) begin
                errors++;
                $display("FAIL maxpos_sample%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, bus.validSamp_R14H,
                         $signed(bus.sample_R14S[0]), $signed(bus.sample_R14S[1]), exp_x[i], exp_y[i]);
            end
        end
        @(negedge clk);
        checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL maxpos_end got %b want 0", bus.validSamp_R14H); end
    endtask

    task automatic test_random();
        logic [3:0] subs[7];
        subs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0011, 4'b1111};
        for (int n = 0; n < 25; n++) begin
            logic [3:0] sub = subs[$urandom_range(0, 6)];
            int   step = step_of(sub);
            int   llx  = $urandom_range(0, 200000) - 100000;
            int   lly  = $urandom_range(0, 200000) - 100000;
            int   urx  = llx + $urandom_range(0, 4 * step - 1);
            int   ury  = lly + $urandom_range(0, 3 * step - 1);
            tri_t t    = rand_tri();
            col_t c    = rand_col();
            model_walk(llx, lly, urx, ury, step);
            @(negedge clk);
            present(t, c, llx, lly, urx, ury, sub);
            for (int i = 0; i < exp_x.size(); i++) begin
                @(negedge clk);
                bus.validTri_R13H = 1'b0;
                checks++;
                if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'(exp_x[i]) || bus.sample_R14S[1] !== 24'(exp_y[i])) begin
                    errors++;
                    $display("FAIL rand%0d_sample%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", n, i, bus.validSamp_R14H,
                             $signed(bus.sample_R14S[0]), $signed(bus.sample_R14S[1]), exp_x[i], exp_y[i]);
                end
                checks++; if (bus.tri_R14S !== t || bus.color_R14U !== c) begin errors++; $display("FAIL rand%0d_tri%0d got %h/%h want %h/%h", n, i, bus.tri_R14S, bus.color_R14U, t, c); end
                checks++; if (bus.halt_RnnnnL !== (i == exp_x.size() - 1)) begin errors++; $display("FAIL rand%0d_halt%0d got %b want %b", n, i, bus.halt_RnnnnL, (i == exp_x.size() - 1)); end
            end
            @(negedge clk);
            checks++; if (bus.validSamp_R14H !== 1'b0) begin errors++; $display("FAIL rand%0d_end got %b want 0", n, bus.validSamp_R14H); end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_single();
        test_back_to_back();
        test_fine_step();
        test_reset_mid_walk();
        test_ignore_and_bad_box();
        test_max_pos();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
